// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle execute unit.
// Integer ALU ops finish in one cycle. MUL/MULH/MULHSU/MULHU use an iterative
// shift-add multiplier. DIV/DIVU/REM/REMU use an iterative restoring divider.
// Valid/ready handshakes on both sides. One instruction is held at a time.
// Optional macro EX_MDU_FAST_MUL_EN: replaces the shift-add multiplier with a
// single array multiplier plus one pipeline register (2-cycle MUL latency).
module ex_mdu #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [4:0]         op_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic               we_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [RADDR_W-1:0] waddr_o,
    output logic               we_o,
    output logic [XLEN-1:0]    wdata_o
);
    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
    localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};
    localparam logic [CNTW-1:0]   CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]   CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0]   CNT_DIV_FIX = CNTW'(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [4:0]        op_r;
    logic [CNTW-1:0]   cnt_r;
    logic              neg_r;      // product / quotient must be negated
    logic              rneg_r;     // remainder must be negated
    logic              div0_r;     // divisor was zero
    logic [XLEN-1:0]   op1_r;      // original dividend, returned as remainder on /0
    logic [2*XLEN-1:0] acc_r;      // product accumulator (or registered product)
    logic [XLEN-1:0]   rem_r;      // partial remainder
    logic [XLEN-1:0]   quo_r;      // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]   dvsr_r;     // divisor magnitude
`ifndef EX_MDU_FAST_MUL_EN
    localparam logic [CNTW-1:0] CNT_MUL_LAST = CNTW'(XLEN - 1);
    logic [2*XLEN-1:0] mcand_r;    // multiplicand, shifted left each step
    logic [XLEN-1:0]   mplier_r;   // multiplier, shifted right each step
    logic [2*XLEN-1:0] acc_nxt_s;
`endif

    logic              accept_s;
    logic              is_mul_s;
    logic              is_div_s;
    logic              sgn1_s;
    logic              sgn2_s;
    logic [XLEN-1:0]   mag1_s;
    logic [XLEN-1:0]   mag2_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_sgn_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   div_res_s;

    // Single-cycle integer ALU; unknown opcodes yield zero.
    function automatic logic [XLEN-1:0] alu_f(input logic [4:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_SLL:  alu_f = a << sh;
            OP_SLT:  alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_f = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  alu_f = a ^ b;
            OP_SRL:  alu_f = a >> sh;
            OP_SRA:  alu_f = $signed(a) >>> sh;
            OP_OR:   alu_f = a | b;
            OP_AND:  alu_f = a & b;
            default: alu_f = ZERO_X;
        endcase
    endfunction

    // Handshake: flush discards an op offered in the same cycle.
    assign ready_o  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & ready_i);
    assign accept_s = valid_i & ready_o & ~flush_i;

    // Incoming op decode: class, operand signs and magnitudes.
    always_comb begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        sgn1_s   = 1'b0;
        sgn2_s   = 1'b0;
        if ((op_i >= OP_MUL) && (op_i <= OP_MULHU)) begin
            is_mul_s = 1'b1;
        end else if ((op_i >= OP_DIV) && (op_i <= OP_REMU)) begin
            is_div_s = 1'b1;
        end else begin
            is_mul_s = 1'b0;
            is_div_s = 1'b0;
        end
        case (op_i)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1_s = op1_i[XLEN-1];
                sgn2_s = op2_i[XLEN-1];
            end
            OP_MULHSU: begin
                sgn1_s = op1_i[XLEN-1];
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        mag1_s = sgn1_s ? (ZERO_X - op1_i) : op1_i;
        mag2_s = sgn2_s ? (ZERO_X - op2_i) : op2_i;
    end

    // Multiplier and divider step / finishing logic.
    always_comb begin
`ifdef EX_MDU_FAST_MUL_EN
        prod_s = acc_r;
`else
        acc_nxt_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        prod_s    = acc_nxt_s;
`endif
        prod_sgn_s = neg_r ? (ZERO_2X - prod_s) : prod_s;
        if (op_r == OP_MUL) begin
            mul_res_s = prod_sgn_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_sgn_s[2*XLEN-1:XLEN];
        end
        rem_sh_s  = {rem_r, quo_r[XLEN-1]};
        diff_s    = rem_sh_s - {1'b0, dvsr_r};
        quo_fix_s = div0_r ? ONES_X : (neg_r ? (ZERO_X - quo_r) : quo_r);
        rem_fix_s = div0_r ? op1_r : (rneg_r ? (ZERO_X - rem_r) : rem_r);
        if ((op_r == OP_REM) || (op_r == OP_REMU)) begin
            div_res_s = rem_fix_s;
        end else begin
            div_res_s = quo_fix_s;
        end
    end

    // Control FSM with registered result outputs and iterative datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            valid_o  <= 1'b0;
            we_o     <= 1'b0;
            waddr_o  <= {RADDR_W{1'b0}};
            wdata_o  <= ZERO_X;
            op_r     <= 5'd0;
            cnt_r    <= CNT_ZERO;
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            div0_r   <= 1'b0;
            op1_r    <= ZERO_X;
            acc_r    <= ZERO_2X;
            rem_r    <= ZERO_X;
            quo_r    <= ZERO_X;
            dvsr_r   <= ZERO_X;
`ifndef EX_MDU_FAST_MUL_EN
            mcand_r  <= ZERO_2X;
            mplier_r <= ZERO_X;
`endif
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        op_r    <= op_i;
                        waddr_o <= waddr_i;
                        we_o    <= we_i;
                        cnt_r   <= CNT_ZERO;
                        neg_r   <= sgn1_s ^ sgn2_s;
                        rneg_r  <= sgn1_s;
                        div0_r  <= (op2_i == ZERO_X);
                        op1_r   <= op1_i;
                        if (is_mul_s) begin
                            valid_o <= 1'b0;
                            state_r <= ST_BUSY;
`ifdef EX_MDU_FAST_MUL_EN
                            acc_r   <= {ZERO_X, mag1_s} * {ZERO_X, mag2_s};
`else
                            acc_r    <= ZERO_2X;
                            mcand_r  <= {ZERO_X, mag1_s};
                            mplier_r <= mag2_s;
`endif
                        end else if (is_div_s) begin
                            valid_o <= 1'b0;
                            state_r <= ST_BUSY;
                            rem_r   <= ZERO_X;
                            quo_r   <= mag1_s;
                            dvsr_r  <= mag2_s;
                        end else begin
                            wdata_o <= alu_f(op_i, op1_i, op2_i);
                            valid_o <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else if ((state_r == ST_DONE) && ready_i) begin
                        valid_o <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    if (op_r <= OP_MULHU) begin
`ifdef EX_MDU_FAST_MUL_EN
                        wdata_o <= mul_res_s;
                        valid_o <= 1'b1;
                        state_r <= ST_DONE;
`else
                        if (cnt_r == CNT_MUL_LAST) begin
                            wdata_o <= mul_res_s;
                            valid_o <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            acc_r    <= acc_nxt_s;
                            mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
                            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                            cnt_r    <= cnt_r + CNT_ONE;
                        end
`endif
                    end else begin
                        if (cnt_r == CNT_DIV_FIX) begin
                            wdata_o <= div_res_s;
                            valid_o <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            if (diff_s[XLEN] == 1'b0) begin
                                rem_r <= diff_s[XLEN-1:0];
                                quo_r <= {quo_r[XLEN-2:0], 1'b1};
                            end else begin
                                rem_r <= rem_sh_s[XLEN-1:0];
                                quo_r <= {quo_r[XLEN-2:0], 1'b0};
                            end
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=32): directed corner cases, randomized
// ops against an arithmetic reference model, back-to-back, backpressure,
// flush and reset scenarios.
module tb_ex_mdu;
    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  op_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef EX_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 34;

    ex_mdu #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i), .waddr_i(waddr_i), .we_i(we_i),
        .valid_o(valid_o), .ready_i(ready_i), .waddr_o(waddr_o), .we_o(we_o),
        .wdata_o(wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V integer/M semantics from plain arithmetic.
    function automatic logic [31:0] ref_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            5'd11: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            5'd12: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
            5'd13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            5'd14: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                else if (ovf) return 32'h80000000;
                else return $signed(a) / $signed(b);
            end
            5'd15: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            5'd16: begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else return $signed(a) % $signed(b);
            end
            5'd17: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op);
        if (op >= 5'd10 && op <= 5'd13) return MUL_LAT;
        else if (op >= 5'd14 && op <= 5'd17) return DIV_LAT;
        else return 1;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 9));
            default: return $urandom();
        endcase
    endfunction

    // Drive one op, wait for acceptance, then count cycles until valid_o.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we,
                         output logic [31:0] res, output logic [4:0] wa_out, output logic we_out,
                         output int lat, output bit rdy_busy);
        int guard;
        guard = 0;
        op_i = op; op1_i = a; op2_i = b; waddr_i = wa; we_i = we; valid_i = 1'b1;
        while (!ready_o && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        rdy_busy = 1'b0;
        while (!valid_o && lat < 200) begin
            if (ready_o) rdy_busy = 1'b1;
            @(posedge clk); #1; lat++;
        end
        res = wdata_o; wa_out = waddr_o; we_out = we_o;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic [4:0] wa; logic we; int lat; bit rb; int seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({valid_o, we_o, waddr_o, wdata_o, ready_o} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b we=%b wa=%0d wd=%h rdy=%b, want 0 0 0 0 1",
                     valid_o, we_o, waddr_o, wdata_o, ready_o);
        end
        rst = 1'b0;
        // Dirty the outputs with a held ALU result, then reset.
        ready_i = 1'b0;
        do_op(5'd0, 32'h11, 32'h22, 5'd9, 1'b1, r, wa, we, lat, rb);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({valid_o, we_o, waddr_o, wdata_o, ready_o} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_clears_outputs: got v=%b we=%b wa=%0d wd=%h rdy=%b, want 0 0 0 0 1",
                     valid_o, we_o, waddr_o, wdata_o, ready_o);
        end
        // Reset in the middle of a divide.
        ready_i = 1'b1;
        op_i = 5'd14; op1_i = 32'd1000; op2_i = 32'd7; waddr_i = 5'd4; we_i = 1'b1; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o || !ready_o) seen++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_div: busy/valid cycles after reset=%0d, want 0", seen);
        end
    endtask

    task automatic test_directed();
        logic [4:0] op; logic [31:0] a, b, e, r; logic [4:0] wa; logic we; int lat; bit rb;
        ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            case (i)
                0:  begin op = 5'd0;  a = 32'h7FFFFFFF; b = 32'h00000001; e = 32'h80000000; end
                1:  begin op = 5'd7;  a = 32'h80000000; b = 32'h00000004; e = 32'hF8000000; end
                2:  begin op = 5'd4;  a = 32'h00000001; b = 32'hFFFFFFFF; e = 32'h00000001; end
                3:  begin op = 5'd3;  a = 32'h00000001; b = 32'hFFFFFFFF; e = 32'h00000000; end
                4:  begin op = 5'd14; a = 32'hFFFFFFF9; b = 32'h00000002; e = 32'hFFFFFFFD; end
                5:  begin op = 5'd16; a = 32'hFFFFFFF9; b = 32'h00000002; e = 32'hFFFFFFFF; end
                6:  begin op = 5'd15; a = 32'h12345678; b = 32'h00000000; e = 32'hFFFFFFFF; end
                7:  begin op = 5'd16; a = 32'h12345678; b = 32'h00000000; e = 32'h12345678; end
                8:  begin op = 5'd14; a = 32'h80000000; b = 32'hFFFFFFFF; e = 32'h80000000; end
                9:  begin op = 5'd16; a = 32'h80000000; b = 32'hFFFFFFFF; e = 32'h00000000; end
                10: begin op = 5'd20; a = 32'h00000005; b = 32'h00000006; e = 32'h00000000; end
                11: begin op = 5'd1;  a = 32'h00000000; b = 32'h00000001; e = 32'hFFFFFFFF; end
                12: begin op = 5'd6;  a = 32'h80000000; b = 32'h00000024; e = 32'h08000000; end
                13: begin op = 5'd14; a = 32'h80000000; b = 32'h00000000; e = 32'hFFFFFFFF; end
                default: begin op = 5'd16; a = 32'hFFFFFFF9; b = 32'h00000000; e = 32'hFFFFFFF9; end
            endcase
            do_op(op, a, b, 5'(i), 1'b1, r, wa, we, lat, rb);
            n_cmp++;
            if (r !== e || lat !== ref_lat(op)) begin
                n_err++;
                $display("FAIL directed_%0d op=%0d: got %h lat %0d, want %h lat %0d",
                         i, op, r, lat, e, ref_lat(op));
            end
        end
    endtask

    task automatic test_mul();
        logic [4:0] op; logic [31:0] a, b, e, r; logic [4:0] wa; logic we; int lat; bit rb;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin op = 5'd13; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; e = 32'hFFFFFFFE; end
                1: begin op = 5'd10; a = 32'hFFFFFFFD; b = 32'h00000005; e = 32'hFFFFFFF1; end
                2: begin op = 5'd11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; e = 32'h00000000; end
                3: begin op = 5'd12; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; e = 32'hFFFFFFFF; end
                default: begin op = 5'd11; a = 32'h80000000; b = 32'h80000000; e = 32'h40000000; end
            endcase
            do_op(op, a, b, 5'd7, 1'b1, r, wa, we, lat, rb);
            n_cmp++;
            if (r !== e || lat !== MUL_LAT || rb !== 1'b0) begin
                n_err++;
                $display("FAIL mul_%0d op=%0d: got %h lat %0d ready_in_busy %0d, want %h lat %0d ready_in_busy 0",
                         i, op, r, lat, rb, e, MUL_LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] op, wa, wa_got; logic [31:0] a, b, r; logic we, we_got; int lat; bit rb;
        ready_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 19));
            a = rand_opnd();
            b = rand_opnd();
            wa = 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            do_op(op, a, b, wa, we, r, wa_got, we_got, lat, rb);
            n_cmp++;
            if (r !== ref_f(op, a, b) || wa_got !== wa || we_got !== we || lat !== ref_lat(op)) begin
                n_err++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h wa %0d we %b lat %0d, want %h wa %0d we %b lat %0d",
                         i, op, a, b, r, wa_got, we_got, lat, ref_f(op, a, b), wa, we, ref_lat(op));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op; logic [31:0] a, b, e;
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = 5'($urandom_range(0, 9));
            a = $urandom();
            b = $urandom();
            e = ref_f(op, a, b);
            op_i = op; op1_i = a; op2_i = b; waddr_i = 5'd1; we_i = 1'b1; valid_i = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (valid_o !== 1'b1 || wdata_o !== e) begin
                n_err++;
                $display("FAIL back_to_back_%0d op=%0d: got v=%b %h, want v=1 %h", i, op, valid_o, wdata_o, e);
            end
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [4:0] wa; logic we; int lat; bit rb;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        do_op(5'd14, 32'hFFFFFFF9, 32'd2, 5'd12, 1'b1, r, wa, we, lat, rb);
        n_cmp++;
        if (r !== 32'hFFFFFFFD || lat !== DIV_LAT) begin
            n_err++;
            $display("FAIL bp_div: got %h lat %0d, want fffffffd lat %0d", r, lat, DIV_LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (valid_o !== 1'b1 || wdata_o !== 32'hFFFFFFFD || waddr_o !== 5'd12 || ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b %h wa %0d rdy %b, want v=1 fffffffd wa 12 rdy 0",
                         i, valid_o, wdata_o, waddr_o, ready_o);
            end
        end
        ready_i = 1'b1;
        op_i = 5'd0; op1_i = 32'd3; op2_i = 32'd4; waddr_i = 5'd2; we_i = 1'b1; valid_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b, want 1", ready_o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b1 || wdata_o !== 32'd7 || waddr_o !== 5'd2) begin
            n_err++;
            $display("FAIL bp_next_op: got v=%b %h wa %0d, want v=1 00000007 wa 2", valid_o, wdata_o, waddr_o);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] wa; logic we; int lat; bit rb; int seen;
        ready_i = 1'b1;
        op_i = 5'd14; op1_i = 32'd100; op2_i = 32'd7; waddr_i = 5'd3; we_i = 1'b1; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_busy: got v=%b rdy=%b, want v=0 rdy=1", valid_o, ready_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL flush_no_result: valid cycles=%0d, want 0", seen);
        end
        // Flush and accept in the same cycle: op discarded.
        op_i = 5'd0; op1_i = 32'd1; op2_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_wins: got v=%b rdy=%b, want v=0 rdy=1", valid_o, ready_o);
        end
        do_op(5'd0, 32'd5, 32'd6, 5'd8, 1'b1, r, wa, we, lat, rb);
        n_cmp++;
        if (r !== 32'd11 || lat !== 1 || wa !== 5'd8) begin
            n_err++;
            $display("FAIL flush_then_add: got %h lat %0d wa %0d, want 0000000b lat 1 wa 8", r, lat, wa);
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = 5'd0; op1_i = 32'd0; op2_i = 32'd0; waddr_i = 5'd0; we_i = 1'b0;
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
